// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: a shared prescaler tick paces per-channel OFF/ON/BLINK/BURST
// engines, each with its own half-period and burst count, configured through a write port.
`timescale 1ns/1ps

module led_blinker_multi #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic                                              CLK50,
  input  logic                                              RST,
  input  logic                                              WR_EN,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] WR_ADDR,
  input  logic [1:0]                                        WR_MODE,
  input  logic [PERIOD_W-1:0]                               WR_PERIOD,
  input  logic [COUNT_W-1:0]                                WR_COUNT,
  output logic [CHANNELS-1:0]                               LED,
  output logic [CHANNELS-1:0]                               BUSY
);

  localparam int unsigned AW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == PW'(DIV - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  mode_t               mode_q  [CHANNELS];
  logic [PERIOD_W-1:0] half_q  [CHANNELS];
  logic [PERIOD_W-1:0] phase_q [CHANNELS];
  logic [COUNT_W-1:0]  rem_q   [CHANNELS];
  logic [CHANNELS-1:0] led_q;
  logic [CHANNELS-1:0] busy_q;

  mode_t               wr_mode;
  logic [PERIOD_W-1:0] wr_half;

  always_comb begin
    wr_mode = mode_t'(WR_MODE);
    wr_half = (WR_PERIOD == '0) ? PERIOD_W'(1) : WR_PERIOD;
  end

  // Per-channel decode against each index means out-of-range addresses hit no channel.
  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= MODE_OFF;
        half_q[i]  <= PERIOD_W'(1);
        phase_q[i] <= '0;
        rem_q[i]   <= '0;
      end
      led_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (WR_EN && (WR_ADDR == AW'(i))) begin
          half_q[i]  <= wr_half;
          phase_q[i] <= '0;
          rem_q[i]   <= WR_COUNT;
          case (wr_mode)
            MODE_OFF: begin
              mode_q[i] <= MODE_OFF;
              led_q[i]  <= 1'b0;
              busy_q[i] <= 1'b0;
            end
            MODE_ON: begin
              mode_q[i] <= MODE_ON;
              led_q[i]  <= 1'b1;
              busy_q[i] <= 1'b0;
            end
            MODE_BLINK: begin
              mode_q[i] <= MODE_BLINK;
              led_q[i]  <= 1'b1;
              busy_q[i] <= 1'b0;
            end
            MODE_BURST: begin
              if (WR_COUNT != '0) begin
                mode_q[i] <= MODE_BURST;
                led_q[i]  <= 1'b1;
                busy_q[i] <= 1'b1;
              end else begin
                mode_q[i] <= MODE_OFF;
                led_q[i]  <= 1'b0;
                busy_q[i] <= 1'b0;
              end
            end
          endcase
        end else if (tick && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BURST)) begin
          if (phase_q[i] == half_q[i] - 1'b1) begin
            phase_q[i] <= '0;
            if (mode_q[i] == MODE_BLINK || led_q[i]) begin
              led_q[i] <= ~led_q[i];
            end else if (rem_q[i] > COUNT_W'(1)) begin
              rem_q[i] <= rem_q[i] - 1'b1;
              led_q[i] <= 1'b1;
            end else begin
              // Last burst cycle consumed: LED stays dark and the channel parks in OFF.
              rem_q[i]  <= '0;
              mode_q[i] <= MODE_OFF;
              busy_q[i] <= 1'b0;
            end
          end else begin
            phase_q[i] <= phase_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign LED  = led_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_led_blinker_multi.sv
// Directed bench for led_blinker_multi with DIV=10; n counts CLK50 edges since reset release,
// so prescaler ticks land on edges where n is a multiple of 10.
`timescale 1ns/1ps

module tb_led_blinker_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_en5 = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [2:0] wr_addr5 = '0;
  logic [1:0] wr_mode = '0;
  logic [15:0] wr_period = '0;
  logic [7:0] wr_count = '0;
  logic [3:0] led, busy;
  logic [4:0] led5, busy5;

  int ncmp = 0;
  int nerr = 0;
  int n = 0;
  int hi = 0;
  int bz = 0;

  always #5 clk = ~clk;

  led_blinker_multi #(
    .CLK_HZ(10), .TICK_HZ(1), .CHANNELS(4), .PERIOD_W(16), .COUNT_W(8)
  ) u_dut (
    .CLK50(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_MODE(wr_mode),
    .WR_PERIOD(wr_period), .WR_COUNT(wr_count), .LED(led), .BUSY(busy)
  );

  // Five channels give a 3-bit address, so addresses 5..7 are genuinely out of range.
  led_blinker_multi #(
    .CLK_HZ(10), .TICK_HZ(1), .CHANNELS(5), .PERIOD_W(16), .COUNT_W(8)
  ) u_dut5 (
    .CLK50(clk), .RST(rst), .WR_EN(wr_en5), .WR_ADDR(wr_addr5), .WR_MODE(wr_mode),
    .WR_PERIOD(wr_period), .WR_COUNT(wr_count), .LED(led5), .BUSY(busy5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic go(input int target);
    step(target - n);
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] m, input logic [15:0] p,
                    input logic [7:0] c);
    wr_addr = a; wr_mode = m; wr_period = p; wr_count = c; wr_en = 1'b1;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic wr5(input logic [2:0] a, input logic [1:0] m, input logic [15:0] p,
                     input logic [7:0] c);
    wr_addr5 = a; wr_mode = m; wr_period = p; wr_count = c; wr_en5 = 1'b1;
    step(1);
    wr_en5 = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_led5", 32'(led5), 32'h0);
    chk("rst_busy5", 32'(busy5), 32'h0);

    // BLINK ch0, period 3: ticks at 10,20 advance phase, toggle at 30, then every 30.
    wr(2'd0, 2'd2, 16'd3, 8'd0);
    chk("blink_wr_led", 32'(led), 32'h1);
    chk("blink_wr_busy", 32'(busy), 32'h0);
    go(29); chk("blink_pre_t1", 32'(led), 32'h1);
    go(30); chk("blink_t1", 32'(led), 32'h0);
    go(59); chk("blink_pre_t2", 32'(led), 32'h0);
    go(60); chk("blink_t2", 32'(led), 32'h1);

    // BURST ch1, period 2, count 3: written at n=61, falls 80/120/160, rises 100/140, ends 180.
    wr(2'd1, 2'd3, 16'd2, 8'd3);
    chk("burst_wr_led", 32'(led), 32'h3);
    chk("burst_wr_busy", 32'(busy), 32'h2);
    hi = 0; bz = 0;
    while (n < 200) begin
      step(1);
      if (led[1]) hi++;
      if (busy[1]) bz++;
      if (n == 80)  chk("burst_fall1", 32'(led[1]), 32'h0);
      if (n == 100) chk("burst_rise2", 32'(led[1]), 32'h1);
      if (n == 179) chk("burst_busy_last", 32'(busy[1]), 32'h1);
      if (n == 180) begin
        chk("burst_end_busy", 32'(busy[1]), 32'h0);
        chk("burst_end_led", 32'(led[1]), 32'h0);
      end
    end
    chk("burst_high_cycles", 32'(hi), 32'd58);
    chk("burst_busy_cycles", 32'(bz), 32'd118);
    chk("burst_off_led", 32'(led[1]), 32'h0);
    chk("burst_off_busy", 32'(busy), 32'h0);

    // Period 0 acts as 1 on ch2: toggles on every tick.
    wr(2'd2, 2'd2, 16'd0, 8'd0);
    chk("p0_wr", 32'(led[2]), 32'h1);
    go(209); chk("p0_pre", 32'(led[2]), 32'h1);
    go(210); chk("p0_t1", 32'(led[2]), 32'h0);
    go(220); chk("p0_t2", 32'(led[2]), 32'h1);

    // Collision: rewrite ch0 on the tick edge n=230; first toggle at 260, not 250.
    go(229); chk("coll_pre_led0", 32'(led[0]), 32'h0);
    wr(2'd0, 2'd2, 16'd3, 8'd0);
    chk("coll_wr_led0", 32'(led[0]), 32'h1);
    chk("coll_ch2_tick", 32'(led[2]), 32'h0);
    go(250); chk("coll_no_early", 32'(led[0]), 32'h1);
    go(260); chk("coll_toggle", 32'(led[0]), 32'h0);
    chk("coll_ch2_260", 32'(led[2]), 32'h1);

    // BURST with count 0 forces OFF immediately.
    wr(2'd1, 2'd1, 16'd5, 8'd0);
    chk("on_led1", 32'(led[1]), 32'h1);
    wr(2'd1, 2'd3, 16'd5, 8'd0);
    chk("cnt0_led1", 32'(led[1]), 32'h0);
    chk("cnt0_busy1", 32'(busy[1]), 32'h0);

    // Out-of-range addresses on the five-channel instance change nothing.
    wr5(3'd5, 2'd1, 16'd1, 8'd0);
    chk("addr5_led", 32'(led5), 32'h0);
    wr5(3'd7, 2'd3, 16'd1, 8'd2);
    chk("addr7_led", 32'(led5), 32'h0);
    chk("addr7_busy", 32'(busy5), 32'h0);
    wr5(3'd4, 2'd1, 16'd1, 8'd0);
    chk("addr4_led", 32'(led5), 32'h10);

    go(290);
    chk("cnt0_stays_led", 32'(led[1]), 32'h0);
    chk("cnt0_stays_busy", 32'(busy[1]), 32'h0);

    // BURST ch3 written at n=291; second cycle starts at 330. Reset asynchronously at 335.
    wr(2'd3, 2'd3, 16'd2, 8'd3);
    go(335);
    chk("mid_led3", 32'(led[3]), 32'h1);
    chk("mid_busy3", 32'(busy[3]), 32'h1);
    rst = 1'b1;
    #2;
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_led5", 32'(led5), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    chk("rel_led", 32'(led), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);

    // Prescaler restarted: first tick consumed on the 10th edge after release.
    wr(2'd0, 2'd2, 16'd1, 8'd0);
    chk("tick_wr", 32'(led), 32'h1);
    go(9);  chk("tick_pre", 32'(led[0]), 32'h1);
    go(10); chk("tick_first", 32'(led[0]), 32'h0);
    go(20); chk("tick_second", 32'(led[0]), 32'h1);
    go(40);
    chk("ch3_stays_off", 32'(led[3]), 32'h0);
    chk("ch3_busy_off", 32'(busy), 32'h0);
    wr(2'd3, 2'd1, 16'd4, 8'd0);
    chk("ch3_rewrite_led", 32'(led[3]), 32'h1);
    chk("ch3_rewrite_busy", 32'(busy[3]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
